// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential restoring divider: default width
// and the three-state FSM encoding.
package seq_divider_pkg;

    localparam int WORDSIZE_DEFAULT = 64;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/seq_divider_adder_sub.sv
// Combinational adder-subtractor: o_result = i_a + i_b, or i_a - i_b when
// i_operation is 1.
module adder_sub #(
    parameter int WIDTH = 65
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_operation,
    output logic [WIDTH-1:0] o_result
);

    assign o_result = i_operation ? (i_a - i_b) : (i_a + i_b);

endmodule

// File: rtl/seq_divider.sv
// Unsigned sequential restoring divider, one quotient bit per RUN cycle.
// Divide-by-zero returns all-ones quotient and the dividend as remainder.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WORDSIZE = WORDSIZE_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WORDSIZE-1:0] dividend,
    input  logic [WORDSIZE-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic [WORDSIZE-1:0] quotient,
    output logic [WORDSIZE-1:0] remainder
);

    localparam int CW = $clog2(WORDSIZE);
    localparam logic [CW-1:0] COUNT_LAST = CW'(WORDSIZE - 1);

    logic [1:0]          r_state;
    logic [CW-1:0]       r_count;
    logic [WORDSIZE-1:0] r_dividend;
    logic [WORDSIZE-1:0] r_divisor;
    logic [WORDSIZE-1:0] r_rem;
    logic [WORDSIZE-1:0] r_quot;
    logic [WORDSIZE-1:0] r_quotient_out;
    logic [WORDSIZE-1:0] r_remainder_out;

    logic [WORDSIZE:0]   w_shifted;
    logic [WORDSIZE:0]   w_diff;
    logic                w_fits;
    logic [WORDSIZE-1:0] w_rem_next;
    logic [WORDSIZE-1:0] w_quot_next;

    // Dividend bits are consumed MSB first by indexing with the down-counter,
    // so the captured dividend register itself never shifts.
    assign w_shifted = {r_rem, r_dividend[r_count]};

    adder_sub #(
        .WIDTH(WORDSIZE + 1)
    ) u_adder_sub (
        .i_a        (w_shifted),
        .i_b        ({1'b0, r_divisor}),
        .i_operation(1'b1),
        .o_result   (w_diff)
    );

    assign w_fits      = ~w_diff[WORDSIZE];
    assign w_rem_next  = w_fits ? w_diff[WORDSIZE-1:0] : w_shifted[WORDSIZE-1:0];
    assign w_quot_next = {r_quot[WORDSIZE-2:0], w_fits};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_count         <= '0;
            r_dividend      <= '0;
            r_divisor       <= '0;
            r_rem           <= '0;
            r_quot          <= '0;
            r_quotient_out  <= '0;
            r_remainder_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dividend <= dividend;
                        r_divisor  <= divisor;
                        r_rem      <= '0;
                        r_quot     <= '0;
                        r_count    <= COUNT_LAST;
                        if (divisor == '0) begin
                            r_state         <= S_DONE;
                            r_quotient_out  <= '1;
                            r_remainder_out <= dividend;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_rem  <= w_rem_next;
                    r_quot <= w_quot_next;
                    // Results only reach the outputs on the final step.
                    if (r_count == '0) begin
                        r_state         <= S_DONE;
                        r_quotient_out  <= w_quot_next;
                        r_remainder_out <= w_rem_next;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign done      = (r_state == S_DONE);
    assign quotient  = r_quotient_out;
    assign remainder = r_remainder_out;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WORDSIZE=64): a vector table plus
// hand-written sequences for ignored start, mid-run reset and back-to-back use.
module tb_seq_divider;

    localparam int W = 64;
    localparam int MAX_WAIT = 200;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int checks   = 0;
    int failures = 0;

    seq_divider #(.WORDSIZE(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           lat;
    } vec_t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge after the done cycle.
    task automatic run_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input int elat);
        int  cyc;
        int  busy_cyc;
        bit  seen;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        busy_cyc = 0;
        seen     = 1'b0;
        for (cyc = 1; cyc <= MAX_WAIT; cyc++) begin
            if (busy) busy_cyc++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_done_seen"}, W'(seen), W'(1));
        check({name, "_latency"}, W'(cyc), W'(elat));
        check({name, "_busy_cycles"}, W'(busy_cyc), W'(elat));
        check({name, "_quotient"}, quotient, eq);
        check({name, "_remainder"}, remainder, er);
        @(negedge clk);
        check({name, "_done_single"}, W'(done), W'(0));
        check({name, "_busy_after"}, W'(busy), W'(0));
        check({name, "_quotient_held"}, quotient, eq);
        check({name, "_remainder_held"}, remainder, er);
    endtask

    initial begin
        vec_t vecs[9];
        int   n_done;
        int   first_done;
        int   second_done;

        vecs[0] = '{dvd: 64'd100, dvs: 64'd7, q: 64'd14, r: 64'd2, lat: 65};
        vecs[1] = '{dvd: 64'd5, dvs: 64'd0, q: ONES, r: 64'd5, lat: 1};
        vecs[2] = '{dvd: ONES, dvs: 64'd1, q: ONES, r: 64'd0, lat: 65};
        vecs[3] = '{dvd: 64'd3, dvs: 64'd10, q: 64'd0, r: 64'd3, lat: 65};
        vecs[4] = '{dvd: 64'd0, dvs: 64'd3, q: 64'd0, r: 64'd0, lat: 65};
        vecs[5] = '{dvd: 64'd12345678, dvs: 64'd1000, q: 64'd12345, r: 64'd678, lat: 65};
        vecs[6] = '{dvd: 64'h8000_0000_0000_0000, dvs: 64'd3,
                    q: 64'd3074457345618258602, r: 64'd2, lat: 65};
        vecs[7] = '{dvd: ONES, dvs: 64'h8000_0000_0000_0001,
                    q: 64'd1, r: 64'h7FFF_FFFF_FFFF_FFFE, lat: 65};
        vecs[8] = '{dvd: 64'd0, dvs: 64'd0, q: ONES, r: 64'd0, lat: 1};

        reset    = 1'b1;
        start    = 1'b1;
        dividend = 64'd77;
        divisor  = 64'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", W'(busy), W'(0));
        check("reset_done", W'(done), W'(0));
        check("reset_quotient", quotient, '0);
        check("reset_remainder", remainder, '0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_div($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].lat);
        end

        // Start toggling and operand churn during RUN must not disturb 1000 / 9.
        dividend   = 64'd1000;
        divisor    = 64'd9;
        start      = 1'b1;
        n_done     = 0;
        first_done = 0;
        for (int c = 1; c <= 90; c++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (first_done == 0) begin
                    first_done = c;
                    check("churn_quotient", quotient, 64'd111);
                    check("churn_remainder", remainder, 64'd1);
                end
            end
            start    = (c < 60) ? c[0] : 1'b0;
            dividend = {32'(c), 32'($urandom)};
            divisor  = 64'($urandom_range(0, 5));
        end
        check("churn_done_count", W'(n_done), W'(1));
        check("churn_latency", W'(first_done), W'(65));

        // Reset 20 cycles into RUN aborts the division with no done pulse.
        dividend = 64'd100;
        divisor  = 64'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("abort_busy_before", W'(busy), W'(1));
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", W'(busy), W'(0));
        check("abort_done", W'(done), W'(0));
        check("abort_quotient", quotient, '0);
        check("abort_remainder", remainder, '0);
        reset  = 1'b0;
        n_done = 0;
        for (int c = 0; c < 70; c++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("abort_no_done", W'(n_done), W'(0));
        run_div("after_abort", 64'd50, 64'd5, 64'd10, 64'd0, 65);

        // Back-to-back: start held high across two divisions.
        dividend    = 64'd42;
        divisor     = 64'd5;
        start       = 1'b1;
        first_done  = 0;
        second_done = 0;
        n_done      = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1) begin
                dividend = 64'd9;
                divisor  = 64'd3;
            end
            if (done) begin
                n_done++;
                if (first_done == 0) begin
                    first_done = c;
                    check("b2b_first_quotient", quotient, 64'd8);
                    check("b2b_first_remainder", remainder, 64'd2);
                end else if (second_done == 0) begin
                    second_done = c;
                    start = 1'b0;
                    check("b2b_second_quotient", quotient, 64'd3);
                    check("b2b_second_remainder", remainder, 64'd0);
                end
            end
        end
        check("b2b_done_count", W'(n_done), W'(2));
        check("b2b_first_latency", W'(first_done), W'(65));
        check("b2b_separation", W'(second_done - first_done), W'(66));
        check("b2b_idle_busy", W'(busy), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WORDSIZE, default 64, setting the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a division; sampled only in IDLE.
REQ-005 The block SHALL have port dividend, input, WORDSIZE bits: unsigned dividend, captured when start is accepted.
REQ-006 The block SHALL have port divisor, input, WORDSIZE bits: unsigned divisor, captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-009 The block SHALL have port quotient, output, WORDSIZE bits: unsigned quotient.
REQ-010 The block SHALL have port remainder, output, WORDSIZE bits: unsigned remainder.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 In IDLE with start=1, the block SHALL capture dividend and divisor into internal registers on that edge, clear the partial remainder and load the iteration counter with WORDSIZE-1.
REQ-013 On the same edge, the FSM SHALL go to RUN if the divisor is nonzero and directly to DONE if it is zero.
REQ-014 Each RUN cycle SHALL perform one restoring step.
- Shift {remainder, dividend MSB} left by one.
- Subtract the divisor through the shared adder-subtractor (operation=1), computed at WORDSIZE+1 bits.
- If the result MSB is 0: keep the difference and shift quotient bit 1 in.
- Otherwise: keep the shifted remainder and shift quotient bit 0 in.
REQ-015 RUN SHALL last exactly WORDSIZE cycles; when the counter reaches 0, the FSM SHALL go to DONE and SHALL NOT wrap the counter.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 For a nonzero divisor, done SHALL assert in the cycle after WORDSIZE+1 rising edges counted from the edge that accepted start.
REQ-018 For divisor=0, done SHALL assert in the cycle after that edge, with quotient = all ones and remainder = dividend (RISC-V DIVU/REMU semantics).
REQ-019 start SHALL be ignored while busy=1, and captured operands SHALL NOT change during RUN.
REQ-020 quotient and remainder SHALL hold the last result from DONE until the next accepted start.
REQ-021 The outputs SHALL NOT show intermediate RUN values.
REQ-022 If start=1 in the IDLE cycle right after DONE, that start SHALL be accepted normally, giving back-to-back operation.

Reset
REQ-023 While reset=1 at a rising edge, the FSM SHALL enter IDLE, and busy, done, quotient, remainder, the counter and all internal registers SHALL become 0.
REQ-024 reset SHALL take priority over start and SHALL abort a division in progress with no done pulse.

Structure
REQ-025 The FSM state encoding (IDLE, RUN, DONE) and the default WORDSIZE constant SHALL live in the shared package.
REQ-026 The block SHALL instantiate one adder_sub sub-module with WORDSIZE+1 and operation tied to 1 (subtract), and SHALL NOT contain a separate subtractor.
REQ-027 The counter SHALL be $clog2(WORDSIZE) bits wide.

Verification (WORDSIZE=64)
REQ-028 Basic division: start with 100 / 7 -> exactly one done pulse 65 edges after acceptance; quotient=14, remainder=2; busy high for 65 cycles.
REQ-029 Divide by zero: start with 5 / 0 -> done 1 edge after acceptance; quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=5.
REQ-030 Boundary values: 0xFFFF_FFFF_FFFF_FFFF / 1 -> quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0; 3 / 10 -> quotient=0, remainder=3.
REQ-031 Ignored start and operand changes: toggle start and change dividend/divisor during RUN of 1000 / 9 -> result still quotient=111, remainder=1, with a single done pulse.
REQ-032 Reset mid-operation: assert reset 20 cycles into RUN -> next cycle busy=0, quotient=0, remainder=0, no done pulse; a following 50 / 5 -> quotient=10, remainder=0.
REQ-033 Back-to-back: start held high through two operations (42 / 5, then 9 / 3) -> done pulses separated by exactly 66 cycles; results 8 r2, then 3 r0.
